histoframe_accel_mul_pipe_acc: RTL
==================================

// Module: histoframe_accel_mul_pipe_acc
// PURPOSE
//  Parametrised pipelined multiplier (optional multiply-accumulate) for histoframe_accel datapath.
//  Generalises the fixed 16x16->26 DSP multiplier: configurable operand widths, per-operand
//  signedness, pipeline depth, valid tagging with clock-enable stall. Maps onto DSP48 slices.
//  Used for bin index scaling (row*stride) and per-bin weighted histogram accumulation.
// PARAMETERS
//  DIN0_WIDTH   16  operand A width (1..27)
//  DIN1_WIDTH   16  operand B width (1..18)
//  DOUT_WIDTH   26  result/accumulator width; low DOUT_WIDTH bits of product/sum kept
//  NUM_STAGE    4   total latency in ce-qualified cycles, legal 2..8 (else $error at elaboration)
//  DIN0_SIGNED  0   1: din0 two's complement; 0: unsigned (zero-extended)
//  DIN1_SIGNED  0   1: din1 two's complement; 0: unsigned (zero-extended)
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  reset      in   1           synchronous, active-high reset
//  ce         in   1           clock enable; 0 freezes every pipeline register incl. valid
//  in_valid   in   1           din0/din1 (and acc_clr) qualify a sample this cycle
//  din0       in   DIN0_WIDTH  operand A
//  din1       in   DIN1_WIDTH  operand B
//  acc_clr    in   1           with in_valid: restart accumulation at this sample (ACC mode only)
//  dout       out  DOUT_WIDTH  product (or running sum), registered
//  out_valid  out  1           dout carries result of a valid sample
// BEHAVIOUR
//  - Reset: all data/valid/acc registers <= 0; dout=0, out_valid=0 the cycle after reset high.
//    reset has priority over ce; reset mid-pipeline discards all in-flight samples.
//  - Stage 1: register din0, din1, in_valid, acc_clr. Stage 2: full product register,
//    width DIN0_WIDTH+DIN1_WIDTH+1, each operand extended by 1 bit per its *_SIGNED.
//  - Stages 3..NUM_STAGE-1: pure delay. Stage NUM_STAGE: output register (dout).
//    NUM_STAGE=2: stage 2 is the output register itself.
//  - Latency: sample accepted at ce-cycle N appears on dout/out_valid at ce-cycle N+NUM_STAGE.
//  - ce=0: no register changes; dout/out_valid hold; samples resume without loss when ce=1.
//    in_valid while ce=0 is ignored (sample dropped; upstream must hold ce=1 to issue).
//  - Data registers load every ce cycle regardless of valid (non-ACC); out_valid is the
//    delayed in_valid and is the only qualifier. dout on invalid cycles is don't-care.
//  - Truncation: dout = product[DOUT_WIDTH-1:0]; no saturation, no rounding.
//    If DOUT_WIDTH > product width, product is sign/zero extended per signedness.
//  - Valid bits form a NUM_STAGE-deep shift register; back-to-back samples every cycle supported.
// CONFIGURATION
//  Macro HISTOFRAME_MUL_ACC_EN:
//  - Defined: output register becomes accumulator. On ce and delayed valid=1:
//    acc <= (delayed acc_clr ? 0 : acc) + product[DOUT_WIDTH-1:0], modulo 2^DOUT_WIDTH.
//    On delayed valid=0: acc holds. dout=acc; out_valid pulses per accumulated sample.
//    Latency unchanged (NUM_STAGE). First sample after reset accumulates onto 0.
//  - Undefined: acc_clr ignored (port kept, unconnected internally); plain pipelined multiply.
// TESTING
//  T1 unsigned default: din0=65535,din1=65535,in_valid=1 -> 4 cycles later out_valid=1,
//     dout=0xFFFE0001 & 0x3FFFFFF = 0x3FE0001.
//  T2 streaming: 8 back-to-back pairs (k,k+1), k=0..7 -> 8 consecutive out_valid, dout=k*(k+1),
//     in order, first at cycle 4.
//  T3 stall: issue 3 samples, ce=0 for 5 cycles mid-flight -> dout/out_valid frozen; after ce=1
//     results emerge with no loss/duplication, total ce-cycle latency 4.
//  T4 signed (DIN0_SIGNED=1,DIN1_SIGNED=1): din0=-3,din1=7 -> dout=-21 (26-bit 0x3FFFFEB).
//  T5 reset mid-flight: 2 samples in pipeline, reset 1 cycle -> out_valid=0, dout=0, no late
//     out_valid from discarded samples.
//  T6 ACC_EN: (2,3,clr=1),(4,5),(1,1),(6,6,clr=1) -> dout sequence 6,26,27,36, out_valid each.

Source files
------------

// File: rtl/histoframe_accel_mul_pipe_acc.sv
// Pipelined multiplier with valid tagging and clock-enable stall for the histoframe datapath.
// Define HISTOFRAME_MUL_ACC_EN to turn the output register into a multiply-accumulator.
module histoframe_accel_mul_pipe_acc #(
    parameter int unsigned DIN0_WIDTH  = 16,
    parameter int unsigned DIN1_WIDTH  = 16,
    parameter int unsigned DOUT_WIDTH  = 26,
    parameter int unsigned NUM_STAGE   = 4,
    parameter int unsigned DIN0_SIGNED = 0,
    parameter int unsigned DIN1_SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_clr,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_valid
);

    localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int unsigned EXT_WIDTH  = (PROD_WIDTH > DOUT_WIDTH) ? PROD_WIDTH : DOUT_WIDTH;
    localparam int unsigned DLY_DEPTH  = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 0;

`ifdef HISTOFRAME_MUL_ACC_EN
    localparam int unsigned SB_WIDTH = 2;
`else
    localparam int unsigned SB_WIDTH = 1;
`endif

    generate
        if (NUM_STAGE < 2 || NUM_STAGE > 8) begin : g_bad_stage
            $error("histoframe_accel_mul_pipe_acc: NUM_STAGE must be in 2..8");
        end
    endgenerate

    // Sideband travelling with each sample: bit 0 valid, bit 1 accumulator clear.
    logic [SB_WIDTH-1:0] sb_in_c;
`ifdef HISTOFRAME_MUL_ACC_EN
    assign sb_in_c = {acc_clr, in_valid};
`else
    logic unused_acc_clr;
    assign sb_in_c        = in_valid;
    assign unused_acc_clr = acc_clr;
`endif

    logic [DIN0_WIDTH-1:0] din0_q;
    logic [DIN1_WIDTH-1:0] din1_q;
    logic [SB_WIDTH-1:0]   sb1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            din0_q <= '0;
            din1_q <= '0;
            sb1_q  <= '0;
        end else if (ce) begin
            din0_q <= din0;
            din1_q <= din1;
            sb1_q  <= sb_in_c;
        end
    end

    // Extend both operands to the product width so one unsigned multiply covers every signedness mix.
    logic [PROD_WIDTH-1:0] op0_ext_c;
    logic [PROD_WIDTH-1:0] op1_ext_c;
    logic [PROD_WIDTH-1:0] prod_c;

    always_comb begin
        if (DIN0_SIGNED != 0) op0_ext_c = PROD_WIDTH'($signed(din0_q));
        else                  op0_ext_c = PROD_WIDTH'(din0_q);
        if (DIN1_SIGNED != 0) op1_ext_c = PROD_WIDTH'($signed(din1_q));
        else                  op1_ext_c = PROD_WIDTH'(din1_q);
        prod_c = op0_ext_c * op1_ext_c;
    end

    logic [PROD_WIDTH-1:0] prod_tail;
    logic [SB_WIDTH-1:0]   sb_tail;

    generate
        if (DLY_DEPTH == 0) begin : g_no_dly
            assign prod_tail = prod_c;
            assign sb_tail   = sb1_q;
        end else begin : g_dly
            logic [PROD_WIDTH-1:0] prod_q [DLY_DEPTH];
            logic [SB_WIDTH-1:0]   sb_q   [DLY_DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < int'(DLY_DEPTH); i++) begin
                        prod_q[i] <= '0;
                        sb_q[i]   <= '0;
                    end
                end else if (ce) begin
                    prod_q[0] <= prod_c;
                    sb_q[0]   <= sb1_q;
                    for (int i = 1; i < int'(DLY_DEPTH); i++) begin
                        prod_q[i] <= prod_q[i-1];
                        sb_q[i]   <= sb_q[i-1];
                    end
                end
            end

            assign prod_tail = prod_q[DLY_DEPTH-1];
            assign sb_tail   = sb_q[DLY_DEPTH-1];
        end
    endgenerate

    // The signed product always fits PROD_WIDTH, so sign extension is exact for every mix.
    logic [EXT_WIDTH-1:0]  prod_ext_c;
    logic [DOUT_WIDTH-1:0] prod_trunc_c;
    logic [EXT_WIDTH-1:0]  unused_prod_ext;

    assign prod_ext_c      = EXT_WIDTH'($signed(prod_tail));
    assign prod_trunc_c    = prod_ext_c[DOUT_WIDTH-1:0];
    assign unused_prod_ext = prod_ext_c;

    logic [DOUT_WIDTH-1:0] dout_q;
    logic [DOUT_WIDTH-1:0] dout_d;
    logic                  out_valid_q;

    always_comb begin
`ifdef HISTOFRAME_MUL_ACC_EN
        dout_d = dout_q;
        if (sb_tail[0]) begin
            dout_d = (sb_tail[1] ? '0 : dout_q) + prod_trunc_c;
        end
`else
        dout_d = prod_trunc_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            dout_q      <= dout_d;
            out_valid_q <= sb_tail[0];
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;

endmodule
